// File: rtl/alu_4_bit_accumulator_sequencer.sv
// alu_4_bit_accumulator_sequencer: command FSM driving a 4-bit ALU and capturing its result into an accumulator.
// Optional Flag_Overflow_Out enabled by defining ALU_ACC_OVERFLOW_FLAG_EN.
module alu_4_bit_accumulator_sequencer #(
    parameter logic [3:0] ACC_RESET_VALUE = 4'h0,
    parameter bit         USE_CARRY_CHAIN = 1'b1
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic       Cmd_Valid_In,
    output logic       Cmd_Ready_Out,
    input  logic       Cmd_Load_In,
    input  logic [3:0] Cmd_Op_In,
    input  logic [3:0] Cmd_Operand_In,
    output logic [3:0] Alu_Data_A_Out,
    output logic [3:0] Alu_Data_B_Out,
    output logic       Alu_Carry_Borrowb_Out,
    output logic [3:0] Alu_Operation_Select_Out,
    input  logic [3:0] Alu_Result_In,
    input  logic       Alu_Carry_In,
    output logic [3:0] Acc_Out,
    output logic       Flag_Zero_Out,
    output logic       Flag_Negative_Out,
    output logic       Flag_Carry_Out,
    output logic       Done_Out
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
    ,
    output logic       Flag_Overflow_Out
`endif
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] acc_q, acc_d, sel_q, sel_d, b_q, b_d, ld_val_q, ld_val_d;
    logic       c_q, c_d, cin_q, cin_d, done_q, done_d, v_q, v_d, ovf;
    logic       fire, chain_op;

    assign fire     = Cmd_Valid_In && Cmd_Ready_Out;
    assign chain_op = (Cmd_Op_In == 4'h2) || (Cmd_Op_In == 4'h3) || (Cmd_Op_In == 4'h4);

    // Overflow uses the pre-update accumulator, which is still on ALU port A during CAPTURE
    always_comb begin
        ovf = 1'b0;
        case (sel_q)
            4'h2: ovf = (acc_q[3] == b_q[3]) && (Alu_Result_In[3] != acc_q[3]);
            4'h3: ovf = (acc_q[3] != b_q[3]) && (Alu_Result_In[3] != acc_q[3]);
            4'h4: ovf = (acc_q[3] != b_q[3]) && (Alu_Result_In[3] != b_q[3]);
            4'h5: ovf = acc_q == 4'h7;
            4'h6: ovf = b_q == 4'h7;
            4'h7: ovf = acc_q == 4'h8;
            default: ovf = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sel_d    = sel_q;
        b_d      = b_q;
        ld_val_d = ld_val_q;
        c_d      = c_q;
        cin_d    = cin_q;
        v_d      = v_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire && Cmd_Load_In) begin
                    ld_val_d = Cmd_Operand_In;
                    state_d  = S_LOAD;
                end else if (fire) begin
                    sel_d   = Cmd_Op_In;
                    b_d     = Cmd_Operand_In;
                    cin_d   = USE_CARRY_CHAIN && chain_op && c_q;
                    state_d = S_ISSUE;
                end
            end
            S_LOAD: begin
                acc_d   = ld_val_q;
                c_d     = 1'b0;
                v_d     = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ISSUE: state_d = S_CAPTURE;
            default: begin
                acc_d   = Alu_Result_In;
                c_d     = sel_q[3] ? c_q : Alu_Carry_In;
                v_d     = ovf;
                done_d  = 1'b1;
                sel_d   = 4'h0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q  <= S_IDLE;
            acc_q    <= ACC_RESET_VALUE;
            sel_q    <= 4'h0;
            b_q      <= 4'h0;
            ld_val_q <= 4'h0;
            c_q      <= 1'b0;
            cin_q    <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sel_q    <= sel_d;
            b_q      <= b_d;
            ld_val_q <= ld_val_d;
            c_q      <= c_d;
            cin_q    <= cin_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign Cmd_Ready_Out            = state_q == S_IDLE;
    assign Alu_Data_A_Out           = acc_q;
    assign Alu_Data_B_Out           = b_q;
    assign Alu_Carry_Borrowb_Out    = cin_q;
    assign Alu_Operation_Select_Out = sel_q;
    assign Acc_Out                  = acc_q;
    assign Flag_Zero_Out            = acc_q == 4'h0;
    assign Flag_Negative_Out        = acc_q[3];
    assign Flag_Carry_Out           = c_q;
    assign Done_Out                 = done_q;
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
    assign Flag_Overflow_Out        = v_q;
`else
    logic unused_v;
    assign unused_v = v_q ^ ovf;
`endif
endmodule

// File: tb/tb_alu_4_bit_accumulator_sequencer.sv
// tb_alu_4_bit_accumulator_sequencer: directed self-checking bench; the bench plays the ALU with hand-computed results.
module tb_alu_4_bit_accumulator_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0, load = 1'b0, alu_c = 1'b0;
    logic [3:0] op = 4'h0, opnd = 4'h0, alu_res = 4'h0;
    logic       ready, cin, z, n, c, done;
    logic [3:0] a, b, sel, acc;
    int         n_chk = 0, n_fail = 0;
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
    logic       v;
`endif

    always #5 clk = ~clk;

    alu_4_bit_accumulator_sequencer dut (
        .Clock_In(clk), .Reset_In(rst), .Cmd_Valid_In(valid), .Cmd_Ready_Out(ready),
        .Cmd_Load_In(load), .Cmd_Op_In(op), .Cmd_Operand_In(opnd),
        .Alu_Data_A_Out(a), .Alu_Data_B_Out(b), .Alu_Carry_Borrowb_Out(cin),
        .Alu_Operation_Select_Out(sel), .Alu_Result_In(alu_res), .Alu_Carry_In(alu_c),
        .Acc_Out(acc), .Flag_Zero_Out(z), .Flag_Negative_Out(n), .Flag_Carry_Out(c),
        .Done_Out(done)
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
        , .Flag_Overflow_Out(v)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command and return 1ns after the handshake edge
    task automatic send(input logic ld, input logic [3:0] o, input logic [3:0] d);
        int k = 0;
        valid = 1'b1; load = ld; op = o; opnd = d;
        while (!ready && k < 20) begin
            tick;
            k++;
        end
        chk("accept_timeout", 4'(k < 20), 4'h1);
        tick;
        valid = 1'b0;
    endtask

    // From ISSUE: step through CAPTURE and land on the Done cycle
    task automatic finish_op;
        chk("issue_ready", ready, 1'b0);
        tick;
        chk("capture_done", done, 1'b0);
        tick;
        chk("op_done", done, 1'b1);
        chk("op_sel_restored", sel, 4'h0);
    endtask

    task automatic chk_v(input logic exp);
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
        chk("ovf", v, exp);
`else
        if (exp === 1'bx) $display("unexpected x");
`endif
    endtask

    initial begin
        tick;
        tick;
        rst = 1'b0;
        chk("rst_acc", acc, 4'h0);
        chk("rst_z", z, 1'b1);
        chk("rst_n", n, 1'b0);
        chk("rst_c", c, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_sel", sel, 4'h0);
        chk("rst_b", b, 4'h0);
        chk("rst_cin", cin, 1'b0);
        chk_v(1'b0);

        send(1'b1, 4'h0, 4'h9);
        chk("load_busy", ready, 1'b0);
        tick;
        chk("load_done", done, 1'b1);
        chk("load_acc", acc, 4'h9);
        chk("load_a", a, 4'h9);
        chk("load_n", n, 1'b1);
        chk("load_z", z, 1'b0);
        chk("load_c", c, 1'b0);
        chk("load_ready", ready, 1'b1);
        tick;
        chk("load_done_pulse", done, 1'b0);

        alu_res = 4'h1; alu_c = 1'b1;
        send(1'b0, 4'h2, 4'h8);
        chk("add_sel", sel, 4'h2);
        chk("add_b", b, 4'h8);
        chk("add_cin", cin, 1'b0);
        chk("add_a", a, 4'h9);
        finish_op;
        chk("add_acc", acc, 4'h1);
        chk("add_c", c, 1'b1);
        chk_v(1'b1);

        alu_res = 4'h2; alu_c = 1'b0;
        send(1'b0, 4'h2, 4'h0);
        chk("chain_cin", cin, 1'b1);
        finish_op;
        chk("chain_acc", acc, 4'h2);
        chk("chain_c", c, 1'b0);
        chk_v(1'b0);

        send(1'b1, 4'h0, 4'h3);
        tick;
        chk("load3_acc", acc, 4'h3);
        alu_res = 4'hE; alu_c = 1'b1;
        send(1'b0, 4'h3, 4'h5);
        chk("sub_cin", cin, 1'b0);
        finish_op;
        chk("sub_acc", acc, 4'hE);
        chk("sub_c", c, 1'b1);
        chk("sub_n", n, 1'b1);
        chk("sub_z", z, 1'b0);
        chk_v(1'b0);

        send(1'b1, 4'h0, 4'h7);
        tick;
        chk("load7_c", c, 1'b0);
        chk_v(1'b0);
        alu_res = 4'h8; alu_c = 1'b0;
        send(1'b0, 4'h5, 4'h0);
        chk("inc_cin", cin, 1'b0);
        finish_op;
        chk("inc_acc", acc, 4'h8);
        chk_v(1'b1);

        send(1'b1, 4'h0, 4'hC);
        tick;
        alu_res = 4'h5; alu_c = 1'b1;
        send(1'b0, 4'h2, 4'h9);
        finish_op;
        chk("addc_acc", acc, 4'h5);
        chk("addc_c", c, 1'b1);
        chk_v(1'b1);

        // Logic ops leave Carry_Out undriven; driving 0 here exposes any sampling
        alu_res = 4'h0; alu_c = 1'b0;
        send(1'b0, 4'hA, 4'h5);
        chk("xor_cin", cin, 1'b0);
        finish_op;
        chk("xor_acc", acc, 4'h0);
        chk("xor_z", z, 1'b1);
        chk("xor_c_kept", c, 1'b1);
        chk_v(1'b0);

        alu_res = 4'h2; alu_c = 1'b0;
        send(1'b0, 4'h2, 4'h1);
        chk("held_cin", cin, 1'b1);
        valid = 1'b1; load = 1'b1; op = 4'h0; opnd = 4'h6;
        chk("held_issue_ready", ready, 1'b0);
        tick;
        chk("held_capture_ready", ready, 1'b0);
        chk("held_capture_acc", acc, 4'h0);
        tick;
        chk("held_done", done, 1'b1);
        chk("held_acc", acc, 4'h2);
        chk("held_c", c, 1'b0);
        chk("held_ready", ready, 1'b1);
        tick;
        chk("held_accepted", ready, 1'b0);
        chk("held_acc_before_load", acc, 4'h2);
        valid = 1'b0;
        tick;
        chk("held_load_done", done, 1'b1);
        chk("held_load_acc", acc, 4'h6);

        alu_res = 4'h9; alu_c = 1'b0;
        send(1'b0, 4'h2, 4'h3);
        chk("abort_sel", sel, 4'h2);
        rst = 1'b1;
        tick;
        chk("abort_acc", acc, 4'h0);
        chk("abort_c", c, 1'b0);
        chk("abort_ready", ready, 1'b1);
        chk("abort_sel_rst", sel, 4'h0);
        chk("abort_done", done, 1'b0);
        chk("abort_b", b, 4'h0);
        rst = 1'b0;
        tick;
        chk("abort_no_done", done, 1'b0);
        chk("abort_acc_idle", acc, 4'h0);
        chk("abort_ready_idle", ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_4_bit_accumulator_sequencer.md
Name: alu_4_bit_accumulator_sequencer

Overview:
Sequential control stage directly upstream and downstream of the 4-bit ALU. It accepts commands (opcode + 4-bit operand) over a valid/ready handshake and drives the ALU's A/B/Cin/select inputs from registered state. It captures the ALU result and carry into an accumulator and flag registers, then reports completion. The accumulator feeds back as ALU operand A, and the carry flag can feed back as Cin for multi-word chains.

Parameters:
ACC_RESET_VALUE, 4'h0, accumulator value after reset.
USE_CARRY_CHAIN, 1, 1: Carry flag drives ALU Cin for ops 2/3/4; 0: Cin tied 0.

Ports:
Clock_In  input  1  rising-edge clock
Reset_In  input  1  synchronous, active-high reset
Cmd_Valid_In  input  1  command valid
Cmd_Ready_Out  output  1  block can accept command
Cmd_Load_In  input  1  1: load operand directly into accumulator (no ALU op)
Cmd_Op_In  input  4  ALU operation select (0x0-0xF)
Cmd_Operand_In  input  4  ALU operand B / load value
Alu_Data_A_Out  output  4  to ALU Data_A_In
Alu_Data_B_Out  output  4  to ALU Data_B_In
Alu_Carry_Borrowb_Out  output  1  to ALU Carry_Borrowb_In
Alu_Operation_Select_Out  output  4  to ALU Operation_Select_In
Alu_Result_In  input  4  from ALU Result_Out
Alu_Carry_In  input  1  from ALU Carry_Out (undriven for ops 0x8-0xF)
Acc_Out  output  4  accumulator
Flag_Zero_Out  output  1  Acc_Out == 0
Flag_Negative_Out  output  1  Acc_Out[3]
Flag_Carry_Out  output  1  last arithmetic carry/borrow (ALU bit 4)
Done_Out  output  1  one-cycle pulse on accumulator write

Behaviour:
- Reset state: Acc = ACC_RESET_VALUE; Z and N computed from it; C = 0; Done = 0; Ready = 1; Alu_Operation_Select_Out = 4'h0; Alu_Data_B_Out = 0; Alu_Carry_Borrowb_Out = 0; FSM = IDLE.
- Alu_Data_A_Out = Acc at all times.
- FSM states:
  - IDLE: Ready = 1.
    - Handshake when Valid & Ready: latch Load, Op, Operand.
    - Load = 1: go to LOAD.
    - Load = 0: drive select = Op, B = Operand, Cin = (USE_CARRY_CHAIN && Op in {2,3,4}) ? C : 0; go to ISSUE.
  - LOAD: Acc <= Operand; C <= 0; Done = 1; return to IDLE. Handshake-to-Done latency is 1 cycle.
  - ISSUE: Ready = 0; ALU inputs held stable (settle cycle); go to CAPTURE.
  - CAPTURE: Ready = 0; ALU inputs held.
    - Acc <= Alu_Result_In.
    - If Op[3] == 0: C <= Alu_Carry_In.
    - If Op[3] == 1: C retained; Alu_Carry_In is never sampled.
    - Done = 1 for this cycle; return to IDLE and restore select = 4'h0.
    - ALU op latency: 2 cycles handshake-to-Done; throughput is 1 op per 3 cycles.
- Z and N are combinational from Acc and therefore valid in the same cycle as the write.
- Valid while Ready = 0 is ignored; the source holds the command until handshake. A command is accepted on the IDLE cycle immediately after Done.
- All arithmetic is modulo 16; the 5th bit comes only from the ALU.
- Reset mid-operation (LOAD/ISSUE/CAPTURE): the operation is aborted, no Done, and all reset values apply on the next cycle. The ALU sees the same Reset_In and tri-states its outputs; this block never samples ALU inputs while Reset_In = 1.

Optional Feature:
Macro ALU_ACC_OVERFLOW_FLAG_EN.
- Defined: adds output port Flag_Overflow_Out (1 bit, reset 0), updated in CAPTURE. With A = Alu_Data_A_Out, B = Alu_Data_B_Out, R = Alu_Result_In:
  - op 2: (A3 == B3) && (R3 != A3)
  - op 3: (A3 != B3) && (R3 != A3)
  - op 4: (A3 != B3) && (R3 != B3)
  - op 5: A == 4'h7
  - op 6: B == 4'h7
  - op 7: A == 4'h8
  - ops 0, 1, 8-F: cleared to 0
  - LOAD clears it to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset 2 cycles -> Acc = 0, Z = 1, N = 0, C = 0, Ready = 1, Done = 0, select = 0.
2. Load 4'h9 -> one cycle later Acc = 9, N = 1, Z = 0, C = 0, Done pulse 1 cycle; Ready back to 1 the same cycle.
3. Acc = 9; op 2, operand 8 -> 2 cycles later Acc = 1, C = 1. Then op 2, operand 0 with USE_CARRY_CHAIN = 1 -> Cin = 1, Acc = 2, C = 0.
4. Acc = 3, C = 0; op 3, operand 5 -> Acc = 4'hE, C = 1, N = 1, Z = 0. With macro: V = 0. Acc = 7; op 5 -> Acc = 8, V = 1.
5. Acc = 5, C = 1; op 0xA (XOR), operand 5 -> Acc = 0, Z = 1, C stays 1 while ALU Carry_Out is driven Z.
6. Valid held high during ISSUE -> not accepted until the IDLE cycle after Done. Reset asserted during ISSUE -> no Done; next cycle Acc = 0, C = 0, Ready = 1, select = 0.
